// File: rtl/alu_share_seq.sv
// alu_share_seq: round-robin sharing of one 8-bit ALU between two requesters,
// sequencing NBYTES-wide operations one byte per cycle, LSB first.
//
// state | meaning
// IDLE  | waiting for a request; grant, latch op/operands/id
// EXEC  | driving the ALU with byte byte_q and capturing its result
// DONE  | presenting the response until rsp_ready
module alu_share_seq #(
    parameter int NBYTES = 2,
    localparam int W = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rq0_valid,
    output logic         rq0_ready,
    input  logic [2:0]   rq0_op,
    input  logic [W-1:0] rq0_a,
    input  logic [W-1:0] rq0_b,
    input  logic         rq1_valid,
    output logic         rq1_ready,
    input  logic [2:0]   rq1_op,
    input  logic [W-1:0] rq1_a,
    input  logic [W-1:0] rq1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_out,
    output logic         rsp_cout,
    output logic         rsp_zero,
    output logic         rsp_err,
    output logic [2:0]   alu_ctrl,
    output logic [7:0]   alu_a,
    output logic [7:0]   alu_b,
    output logic         alu_cin,
    input  logic [7:0]   alu_out,
    input  logic         alu_cout,
    input  logic         alu_zero
);
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDC = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_NEG  = 3'd5;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t         state_q, state_d;
    logic           rr_q, rr_d;
    logic [CW-1:0]  byte_q, byte_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           id_q, id_d;
    logic [W-1:0]   res_q, res_d;
    logic           carry_q, carry_d;
    logic           zero_q, zero_d;
    logic           err_q, err_d;
    logic           rsp_valid_q, rsp_valid_d;

    logic           pick1;
    logic [2:0]     sel_op;
    logic           supported;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        byte_d      = byte_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        res_d       = res_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        rq0_ready   = 1'b0;
        rq1_ready   = 1'b0;
        pick1       = rq1_valid && (!rq0_valid || rr_q);
        sel_op      = pick1 ? rq1_op : rq0_op;
        supported   = (sel_op == OP_ADD) || (sel_op == OP_AND) ||
                      (sel_op == OP_OR)  || (sel_op == OP_NEG);

        case (state_q)
            IDLE: begin
                if (rq0_valid || rq1_valid) begin
                    rq0_ready   = !pick1;
                    rq1_ready   = pick1;
                    op_d        = sel_op;
                    a_d         = pick1 ? rq1_a : rq0_a;
                    b_d         = pick1 ? rq1_b : rq0_b;
                    id_d        = pick1;
                    rr_d        = !pick1;
                    byte_d      = '0;
                    res_d       = '0;
                    carry_d     = 1'b0;
                    zero_d      = supported;
                    err_d       = !supported;
                    rsp_valid_d = 1'b0;
                    state_d     = supported ? EXEC : DONE;
                end
            end
            EXEC: begin
                res_d[8*byte_q +: 8] = alu_out;
                carry_d              = alu_cout;
                zero_d               = zero_q & alu_zero;
                if (byte_q == CW'(NBYTES - 1)) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                end else begin
                    byte_d = byte_q + CW'(1);
                end
            end
            DONE: begin
                // Unsupported ops arrive here with rsp_valid low and spend one
                // cycle before presenting the error response.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_ctrl = OP_ADD;
        alu_a    = 8'd0;
        alu_b    = 8'd0;
        alu_cin  = 1'b0;
        if (state_q == EXEC) begin
            alu_a = a_q[8*byte_q +: 8];
            alu_b = b_q[8*byte_q +: 8];
            if (op_q == OP_ADD) begin
                if (byte_q != '0) begin
                    alu_ctrl = OP_ADDC;
                    alu_cin  = carry_q;
                end
            end else begin
                alu_ctrl = op_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            byte_q      <= '0;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            byte_q      <= byte_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_out   = res_q;
    assign rsp_cout  = (op_q == OP_ADD) && carry_q;
    assign rsp_zero  = zero_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_share_seq.sv
// Bench for alu_share_seq: ideal 8-bit ALU stub, directed and random ops
// compared against a word-level reference model.
module tb_alu_share_seq;
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDC = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_NEG  = 3'd5;

    logic        clk = 1'b0;
    logic        reset;
    logic        rq0_valid, rq0_ready, rq1_valid, rq1_ready;
    logic [2:0]  rq0_op, rq1_op;
    logic [15:0] rq0_a, rq0_b, rq1_a, rq1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_zero, rsp_err;
    logic [15:0] rsp_out;
    logic [2:0]  alu_ctrl;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic        alu_cin, alu_cout, alu_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        id;
        logic [15:0] o;
        logic        c;
        logic        z;
        logic        e;
    } exp_t;

    exp_t q[$];

    alu_share_seq #(.NBYTES(2)) dut (
        .clk(clk), .reset(reset),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_op(rq0_op), .rq0_a(rq0_a), .rq0_b(rq0_b),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_op(rq1_op), .rq1_a(rq1_a), .rq1_b(rq1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
        .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_cout(alu_cout), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    always_comb begin
        {alu_cout, alu_out} = 9'd0;
        case (alu_ctrl)
            OP_ADD, OP_ADDC: {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
            OP_AND:          alu_out = alu_a & alu_b;
            OP_OR:           alu_out = alu_a | alu_b;
            OP_NEG:          alu_out = 8'd0 - alu_a;
            default:         alu_out = 8'd0;
        endcase
        alu_zero = (alu_out == 8'd0);
    end

    function automatic exp_t model(input logic id, input logic [2:0] op,
                                   input logic [15:0] a, input logic [15:0] b);
        exp_t r;
        logic [16:0] s;
        r.id = id; r.o = 16'd0; r.c = 1'b0; r.e = 1'b0;
        case (op)
            OP_ADD: begin
                s   = {1'b0, a} + {1'b0, b};
                r.o = s[15:0];
                r.c = s[16];
            end
            OP_AND:  r.o = a & b;
            OP_OR:   r.o = a | b;
            OP_NEG:  r.o = {8'(8'd0 - a[15:8]), 8'(8'd0 - a[7:0])};
            default: r.e = 1'b1;
        endcase
        r.z = !r.e && (r.o == 16'd0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rq0_valid = 1'b0; rq1_valid = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Raise valid on one requester, wait (bounded) for its grant, then drop valid.
    task automatic issue(input int rq, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int n;
        @(negedge clk);
        if (rq == 0) begin rq0_op = op; rq0_a = a; rq0_b = b; rq0_valid = 1'b1; end
        else         begin rq1_op = op; rq1_a = a; rq1_b = b; rq1_valid = 1'b1; end
        #1;
        n = 0;
        while (!((rq == 0) ? rq0_ready : rq1_ready) && n < 10) begin
            @(negedge clk); #1; n++;
        end
        chk("grant_seen", 32'(n < 10), 32'd1);
        chk("other_ready", 32'((rq == 0) ? rq1_ready : rq0_ready), 32'd0);
        @(negedge clk);
        rq0_valid = 1'b0; rq1_valid = 1'b0;
    endtask

    // Called at the first negedge after the grant edge.
    task automatic collect(input logic id, input logic [2:0] op, input logic [15:0] a,
                           input logic [15:0] b, input int hold);
        exp_t e;
        int   n;
        logic c0;
        e  = model(id, op, a, b);
        c0 = ({1'b0, a[7:0]} + {1'b0, b[7:0]}) > 9'd255;
        #1;
        n = 1;
        while (!rsp_valid && n < 10) begin
            if (!e.e && n <= 2) begin
                chk("alu_a", 32'(alu_a), 32'((n == 1) ? a[7:0] : a[15:8]));
                chk("alu_b", 32'(alu_b), 32'((n == 1) ? b[7:0] : b[15:8]));
                chk("alu_ctrl", 32'(alu_ctrl), 32'((op == OP_ADD) ? ((n == 1) ? OP_ADD : OP_ADDC) : op));
                chk("alu_cin", 32'(alu_cin), 32'((op == OP_ADD && n == 2) ? c0 : 1'b0));
            end else begin
                chk("alu_a_idle", 32'(alu_a), 32'd0);
                chk("alu_b_idle", 32'(alu_b), 32'd0);
                chk("alu_ctrl_idle", 32'(alu_ctrl), 32'(OP_ADD));
            end
            @(negedge clk); #1; n++;
        end
        chk("latency", 32'(n), 32'(e.e ? 2 : 3));
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_out", 32'(rsp_out), 32'(e.o));
        chk("rsp_cout", 32'(rsp_cout), 32'(e.c));
        chk("rsp_zero", 32'(rsp_zero), 32'(e.z));
        chk("rsp_err", 32'(rsp_err), 32'(e.e));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            rq0_valid = 1'b1; rq1_valid = 1'b1;
            #1;
            chk("hold_ready0", 32'(rq0_ready), 32'd0);
            chk("hold_ready1", 32'(rq1_ready), 32'd0);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_out", 32'(rsp_out), 32'(e.o));
            chk("hold_err", 32'(rsp_err), 32'(e.e));
        end
        @(negedge clk);
        rq0_valid = 1'b0; rq1_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    task automatic sample_stream(inout int ngr, input bit allow_grant);
        exp_t e;
        logic g;
        chk("both_ready", 32'(rq0_ready & rq1_ready), 32'd0);
        if (rsp_valid) begin
            chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rr_rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rr_rsp_out", 32'(rsp_out), 32'(e.o));
                chk("rr_rsp_err", 32'(rsp_err), 32'(e.e));
                chk("rr_rsp_cout", 32'(rsp_cout), 32'(e.c));
            end
        end
        if (allow_grant && (rq0_ready || rq1_ready)) begin
            g = rq1_ready;
            chk("rr_order", 32'(g), 32'(ngr % 2));
            ngr++;
            q.push_back(g ? model(1'b1, rq1_op, rq1_a, rq1_b) : model(1'b0, rq0_op, rq0_a, rq0_b));
        end
    endtask

    initial begin
        int ngr;
        int regr;
        logic [2:0]  op;
        logic [15:0] a, b;
        int rq;

        reset = 1'b1;
        rq0_valid = 1'b0; rq1_valid = 1'b0; rsp_ready = 1'b0;
        rq0_op = OP_ADD; rq1_op = OP_ADD;
        rq0_a = 16'd0; rq0_b = 16'd0; rq1_a = 16'd0; rq1_b = 16'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_out", 32'(rsp_out), 32'd0);
        chk("rst_rsp_flags", 32'({rsp_id, rsp_cout, rsp_zero, rsp_err}), 32'd0);
        chk("rst_alu", 32'({alu_ctrl, alu_a, alu_b, alu_cin}), 32'({OP_ADD, 17'd0}));
        chk("rst_ready", 32'({rq0_ready, rq1_ready}), 32'd0);
        reset = 1'b0;

        issue(0, OP_ADD, 16'h00FF, 16'h0001);
        collect(1'b0, OP_ADD, 16'h00FF, 16'h0001, 0);

        issue(1, OP_ADD, 16'hFFFF, 16'h0001);
        collect(1'b1, OP_ADD, 16'hFFFF, 16'h0001, 0);

        issue(0, OP_SUB, 16'h0005, 16'h0001);
        collect(1'b0, OP_SUB, 16'h0005, 16'h0001, 0);

        issue(0, OP_ADD, 16'h1234, 16'h5678);
        collect(1'b0, OP_ADD, 16'h1234, 16'h5678, 3);

        // Reset while the second byte is on the ALU.
        issue(0, OP_ADD, 16'h12F0, 16'h3420);
        @(negedge clk);
        #1;
        chk("mid_exec_byte1", 32'(alu_ctrl), 32'(OP_ADDC));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        rq0_op = OP_OR;  rq0_a = 16'hA5A5; rq0_b = 16'h0F00; rq0_valid = 1'b1;
        rq1_op = OP_AND; rq1_a = 16'h1111; rq1_b = 16'h2222; rq1_valid = 1'b1;
        #1;
        chk("ptr_reset_rq0", 32'({rq0_ready, rq1_ready}), 32'b10);
        @(negedge clk);
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        collect(1'b0, OP_OR, 16'hA5A5, 16'h0F00, 0);
        issue(1, OP_AND, 16'hF0F0, 16'h0FF0);
        collect(1'b1, OP_AND, 16'hF0F0, 16'h0FF0, 0);

        issue(1, OP_NEG, 16'h0100, 16'h0000);
        collect(1'b1, OP_NEG, 16'h0100, 16'h0000, 1);

        for (int i = 0; i < 14; i++) begin
            rq = int'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            a  = 16'($urandom);
            b  = 16'($urandom);
            issue(rq, op, a, b);
            collect(rq[0], op, a, b, int'($urandom_range(0, 2)));
        end

        // Both requesters continuously valid with the consumer always ready.
        do_reset();
        rsp_ready = 1'b1;
        rq0_op = 3'($urandom_range(0, 7)); rq0_a = 16'($urandom); rq0_b = 16'($urandom);
        rq1_op = 3'($urandom_range(0, 7)); rq1_a = 16'($urandom); rq1_b = 16'($urandom);
        rq0_valid = 1'b1; rq1_valid = 1'b1;
        ngr  = 0;
        regr = -1;
        #1;
        sample_stream(ngr, 1'b1);
        if (rq0_ready || rq1_ready) regr = rq1_ready ? 1 : 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (regr == 0) begin
                rq0_op = 3'($urandom_range(0, 7)); rq0_a = 16'($urandom); rq0_b = 16'($urandom);
            end else if (regr == 1) begin
                rq1_op = 3'($urandom_range(0, 7)); rq1_a = 16'($urandom); rq1_b = 16'($urandom);
            end
            regr = -1;
            #1;
            if (rq0_ready || rq1_ready) regr = rq1_ready ? 1 : 0;
            sample_stream(ngr, 1'b1);
        end
        @(negedge clk);
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            #1;
            sample_stream(ngr, 1'b0);
            @(negedge clk);
        end
        chk("sb_drained", 32'(q.size()), 32'd0);
        chk("rr_grants", 32'(ngr >= 8), 32'd1);
        rsp_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
